// File: rtl/lcd_char_ctrl.sv
// HD44780-class 8-bit write-only character LCD controller: autonomous power-on
// init sequence, then host command/data bytes over a valid/ready handshake.
module lcd_char_ctrl #(
    parameter int CLK_MHZ   = 100,
    parameter int SETUP_CYC = 10,
    parameter int E_CYC     = 50,
    parameter int HOLD_CYC  = 10,
    parameter int POWER_US  = 15000,
    parameter int FS1_US    = 4100,
    parameter int FS2_US    = 100,
    parameter int SHORT_US  = 40,
    parameter int LONG_US   = 1640
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       in_valid_i,
    input  logic       in_rs_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    input  logic       reinit_i,
    output logic       init_done_o,
    output logic       busy_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_data_o,
    output logic [3:0] dbg_step_o
);

    localparam int POWER_CYC = POWER_US * CLK_MHZ;
    localparam int FS1_CYC   = FS1_US * CLK_MHZ;
    localparam int FS2_CYC   = FS2_US * CLK_MHZ;
    localparam int SHORT_CYC = SHORT_US * CLK_MHZ;
    localparam int LONG_CYC  = LONG_US * CLK_MHZ;
    localparam int MAX_PL    = (POWER_CYC > LONG_CYC) ? POWER_CYC : LONG_CYC;
    localparam int MAX_CYC   = (MAX_PL > FS1_CYC) ? MAX_PL : FS1_CYC;
    localparam int CW        = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_POWER,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC,
        S_IDLE
    } state_e;

    typedef enum logic [1:0] {
        W_FS1,
        W_FS2,
        W_SHORT,
        W_LONG
    } wait_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    step_q, step_d;
    logic          host_q, host_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    wait_e         wsel_q, wsel_d;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd5:    return 8'h0C;
            3'd6:    return 8'h01;
            3'd7:    return 8'h06;
            default: return 8'h38;
        endcase
    endfunction

    function automatic wait_e init_wait(input logic [2:0] idx);
        case (idx)
            3'd1:    return W_FS1;
            3'd2:    return W_FS2;
            3'd6:    return W_LONG;
            default: return W_SHORT;
        endcase
    endfunction

    function automatic logic [CW-1:0] wait_load(input wait_e w);
        case (w)
            W_FS1:   return CW'(FS1_CYC - 1);
            W_FS2:   return CW'(FS2_CYC - 1);
            W_LONG:  return CW'(LONG_CYC - 1);
            default: return CW'(SHORT_CYC - 1);
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_POWER;
            cnt_q   <= CW'(POWER_CYC - 1);
            step_q  <= 3'd0;
            host_q  <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            wsel_q  <= W_SHORT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            host_q  <= host_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            wsel_q  <= wsel_d;
        end
    end

    // The counter holds at zero; each state ends on its zero cycle and the
    // next state's length-1 is loaded on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        step_d  = step_q;
        host_d  = host_q;
        pend_d  = pend_q;
        done_d  = done_q;
        rs_d    = rs_q;
        data_d  = data_q;
        wsel_d  = wsel_q;

        if (host_q && state_q != S_IDLE && state_q != S_POWER && reinit_i)
            pend_d = 1'b1;

        case (state_q)
            S_POWER: begin
                if (cnt_q == '0) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    step_d  = 3'd1;
                    host_d  = 1'b0;
                    rs_d    = 1'b0;
                    data_d  = init_byte(3'd1);
                    wsel_d  = init_wait(3'd1);
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = CW'(E_CYC - 1);
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_EXEC;
                    cnt_d   = wait_load(wsel_q);
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    if (host_q) begin
                        host_d = 1'b0;
                        // A reinit seen on the final exec cycle is honoured too.
                        if (pend_q || reinit_i) begin
                            state_d = S_POWER;
                            cnt_d   = CW'(POWER_CYC - 1);
                            step_d  = 3'd0;
                            done_d  = 1'b0;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (step_q == 3'd7) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = CW'(SETUP_CYC - 1);
                        step_d  = step_q + 3'd1;
                        data_d  = init_byte(step_q + 3'd1);
                        wsel_d  = init_wait(step_q + 3'd1);
                    end
                end
            end
            S_IDLE: begin
                if (reinit_i) begin
                    state_d = S_POWER;
                    cnt_d   = CW'(POWER_CYC - 1);
                    step_d  = 3'd0;
                    done_d  = 1'b0;
                    pend_d  = 1'b0;
                end else if (in_valid_i) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    host_d  = 1'b1;
                    rs_d    = in_rs_i;
                    data_d  = in_data_i;
                    wsel_d  = (!in_rs_i && in_data_i[7:2] == 6'd0) ? W_LONG : W_SHORT;
                end
            end
            default: begin
                state_d = S_POWER;
                cnt_d   = CW'(POWER_CYC - 1);
                step_d  = 3'd0;
                host_d  = 1'b0;
                pend_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        dbg_step_o = {1'b0, step_q};
        case (state_q)
            S_POWER: dbg_step_o = 4'd0;
            S_IDLE:  dbg_step_o = 4'd8;
            default: if (host_q) dbg_step_o = 4'd9;
        endcase
    end

    assign in_ready_o  = (state_q == S_IDLE) && !reinit_i && !pend_q;
    assign busy_o      = !in_ready_o;
    assign init_done_o = done_q;
    assign lcd_e_o     = (state_q == S_PULSE);
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Scoreboard bench for lcd_char_ctrl with shortened timing parameters.
module tb_lcd_char_ctrl;

    localparam int E_W = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       reinit = 1'b0;
    logic       in_ready, init_done, busy, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    logic [3:0] dbg_step;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [8:0] exp_q[$];

    lcd_char_ctrl #(
        .CLK_MHZ(1), .SETUP_CYC(1), .E_CYC(2), .HOLD_CYC(1), .POWER_US(20),
        .FS1_US(8), .FS2_US(4), .SHORT_US(3), .LONG_US(6)
    ) dut (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_rs_i(in_rs),
        .in_data_i(in_data), .in_ready_o(in_ready), .reinit_i(reinit),
        .init_done_o(init_done), .busy_o(busy), .lcd_rs_o(lcd_rs),
        .lcd_rw_o(lcd_rw), .lcd_e_o(lcd_e), .lcd_data_o(lcd_data),
        .dbg_step_o(dbg_step)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    // Pulse monitor: each E rising edge pops the scoreboard, each falling edge checks width.
    initial begin : mon
        logic e_prev;
        int   e_w;
        logic [8:0] e;
        e_prev = 1'b0;
        e_w = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                e_prev = 1'b0;
                e_w = 0;
            end else if (lcd_e && !e_prev) begin
                chk("pulse_queued", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pulse_byte", {lcd_rs, lcd_data}, e);
                end
                chk("pulse_rw", lcd_rw, 0);
                e_w = 1;
                e_prev = 1'b1;
            end else if (lcd_e) begin
                e_w++;
            end else if (e_prev) begin
                chk("pulse_width", e_w, E_W);
                e_prev = 1'b0;
            end
        end
    end

    // Called at cycle 0 of POWER_WAIT; counts cycles until init_done.
    task automatic wait_init(input string tag, input int exp_cyc, input bit poke);
        int c;
        int last;
        chk({tag, "_dbg0"}, dbg_step, 0);
        chk({tag, "_done0"}, init_done, 0);
        last = 0;
        for (c = 0; c < 400; c++) begin
            if (int'(dbg_step) != last) begin
                chk({tag, "_dbg_step"}, dbg_step, last + 1);
                last = dbg_step;
            end
            if (init_done) break;
            reinit = poke && (c == 30);
            @(negedge clk);
        end
        reinit = 1'b0;
        chk({tag, "_cycles"}, c, exp_cyc);
        chk({tag, "_dbg_idle"}, dbg_step, 8);
        chk({tag, "_ready"}, in_ready, 1);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input int exp_ready);
        int k;
        int rise;
        for (k = 0; k < 200 && !in_ready; k++) @(negedge clk);
        chk("send_ready", in_ready, 1);
        in_valid = 1'b1;
        in_rs = rs;
        in_data = d;
        exp_q.push_back({rs, d});
        @(negedge clk);
        in_valid = 1'b0;
        chk("send_upd", {lcd_rs, lcd_data}, {rs, d});
        rise = 0;
        for (k = 1; k < 100; k++) begin
            if (in_ready) break;
            if (lcd_e && rise == 0) rise = k;
            @(negedge clk);
        end
        chk("send_e_rise", rise, 2);
        chk("send_ready_ret", k, exp_ready);
        chk("send_hold", {lcd_rs, lcd_data}, {rs, d});
    endtask

    initial begin : main
        logic [7:0] b2b[4];
        int t, tp, j, k;
        bit saw;
        b2b[0] = 8'h61; b2b[1] = 8'h62; b2b[2] = 8'h63; b2b[3] = 8'h64;

        repeat (3) @(negedge clk);
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", init_done, 0);
        chk("rst_busy", busy, 1);
        chk("rst_dbg", dbg_step, 0);

        push_init();
        reset = 1'b0;
        wait_init("init", 78, 1'b1);

        send(1'b1, 8'h41, 8);
        send(1'b0, 8'h01, 11);
        send(1'b0, 8'h04, 8);
        send(1'b0, 8'h02, 11);

        // Back-to-back: in_valid stays high across four bytes.
        tp = 0;
        in_valid = 1'b1;
        in_rs = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = b2b[i];
            exp_q.push_back({1'b1, b2b[i]});
            for (j = 0; j < 50 && !in_ready; j++) @(negedge clk);
            chk("b2b_ready", in_ready, 1);
            t = cyc;
            if (i > 0) chk("b2b_gap", t - tp, 8);
            tp = t;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (j = 0; j < 50 && !in_ready; j++) @(negedge clk);
        chk("b2b_drain", exp_q.size(), 0);

        // reinit beats a simultaneous in_valid in IDLE.
        in_valid = 1'b1;
        in_rs = 1'b1;
        in_data = 8'h55;
        reinit = 1'b1;
        #1 chk("reinit_ready_low", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reinit = 1'b0;
        push_init();
        wait_init("reinit_idle", 78, 1'b0);

        // reinit during a host transfer is taken when EXEC ends.
        in_valid = 1'b1;
        in_rs = 1'b1;
        in_data = 8'h5A;
        exp_q.push_back({1'b1, 8'h5A});
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        push_init();
        saw = 1'b0;
        for (k = 3; k < 100 && dbg_step != 4'd0; k++) begin
            if (in_ready) saw = 1'b1;
            @(negedge clk);
        end
        chk("reinit_host_k", k, 8);
        chk("reinit_host_noready", saw, 0);
        wait_init("reinit_host", 78, 1'b0);

        // Reset in the middle of an E pulse.
        in_valid = 1'b1;
        in_rs = 1'b1;
        in_data = 8'h7E;
        exp_q.push_back({1'b1, 8'h7E});
        @(negedge clk);
        in_valid = 1'b0;
        for (j = 0; j < 20 && !lcd_e; j++) @(negedge clk);
        chk("mid_pulse_e", lcd_e, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_e", lcd_e, 0);
        chk("rst2_ready", in_ready, 0);
        chk("rst2_busy", busy, 1);
        chk("rst2_rs", lcd_rs, 0);
        chk("rst2_data", lcd_data, 0);
        chk("rst2_done", init_done, 0);
        chk("rst2_dbg", dbg_step, 0);
        chk("sb_empty", exp_q.size(), 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_char_ctrl.md
# lcd_char_ctrl

Parametrised HD44780-class character-LCD controller, 8-bit bus, write-only. It runs the full power-on initialisation sequence autonomously, then accepts command and data bytes from a host over a valid/ready handshake. Each byte is sequenced through setup, enable pulse, hold and execution wait, with a long wait for clear and home commands. It sits between the board's LCD pins and any display-formatting logic, replacing the fixed one-character debug sequencer.

## Interface
Parameters (all timings in clock cycles = value × CLK_MHZ where given in µs):
- CLK_MHZ, 100, clock frequency in MHz
- SETUP_CYC, 10, RS/data setup before E rises
- E_CYC, 50, E high width
- HOLD_CYC, 10, E low hold before exec wait
- POWER_US, 15000, power-on wait
- FS1_US, 4100, exec wait after first function set
- FS2_US, 100, exec wait after second function set
- SHORT_US, 40, exec wait for ordinary commands/data
- LONG_US, 1640, exec wait for clear/home

Ports:
- clk  in  1  system clock; the block uses one clock only
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  host byte valid
- in_rs  in  1  0 = command, 1 = data
- in_data  in  8  byte to write
- in_ready  out  1  controller accepts a byte this cycle
- reinit  in  1  single-cycle request to rerun initialisation
- init_done  out  1  initialisation complete
- busy  out  1  high whenever in_ready is low
- lcd_rs  out  1  register select
- lcd_rw  out  1  tied 0
- lcd_e  out  1  enable strobe
- lcd_data  out  8  LCD data bus
- dbg_step  out  4  0 = power wait, 1–7 = init command index, 8 = idle, 9 = host transfer

## Operation
- Reset values: lcd_e=0, lcd_rs=0, lcd_data=0x00, lcd_rw=0, in_ready=0, init_done=0, busy=1, dbg_step=0. Reset asserted mid-transfer drops lcd_e on the next edge.
- States: POWER_WAIT, SETUP, PULSE, HOLD, EXEC, IDLE.
- Init sequence runs after POWER_WAIT. Each entry is a transfer with the exec wait shown:
  1. 0x38 / FS1
  2. 0x38 / FS2
  3. 0x38 / SHORT
  4. 0x38 / SHORT
  5. 0x0C / SHORT
  6. 0x01 / LONG
  7. 0x06 / SHORT
  All with rs=0. After the last one the block enters IDLE and init_done=1, held until reset or reinit.
- Transfer: SETUP (SETUP_CYC cycles, e=0) → PULSE (E_CYC cycles, e=1) → HOLD (HOLD_CYC cycles, e=0) → EXEC (wait cycles, e=0) → next init entry or IDLE.
- Host exec wait is LONG when in_rs=0 and in_data[7:2]==0 (0x01, 0x02, 0x03). Otherwise it is SHORT.
- lcd_rs and lcd_data load when a transfer starts and stay stable through EXEC and IDLE until the next transfer.
- in_ready is 1 only in IDLE with no pending reinit. A byte is accepted when in_valid and in_ready are both 1. The rs/data pair is registered on that edge.
- reinit:
  - In IDLE it wins over a simultaneous in_valid: no byte is accepted, and the block goes to POWER_WAIT with init_done=0.
  - During init it is ignored.
  - During a host transfer it is latched and taken when EXEC ends, instead of returning to IDLE.
- in_valid outside IDLE is ignored. The host must hold the byte until accepted.
- Delay counter is wide enough for $clog2(max(POWER_US, LONG_US, FS1_US)×CLK_MHZ + 1) bits. It reloads at every state entry, with no wrap.

## Timing
- The first cycle after reset deassertion is cycle 0 of POWER_WAIT. POWER_WAIT lasts POWER_US×CLK_MHZ cycles.
- Init transfers run back-to-back with no gap cycles. init_done and in_ready rise on the cycle after the final EXEC cycle.
- Host byte accepted at edge N:
  - lcd_rs/lcd_data update at N+1.
  - lcd_e=1 for cycles N+1+SETUP_CYC … N+SETUP_CYC+E_CYC.
  - in_ready returns at N+1+SETUP_CYC+E_CYC+HOLD_CYC+wait.
- Back-to-back host bytes therefore accept at most once per transfer length.

## Test plan
Parameters for all scenarios: CLK_MHZ=1, SETUP_CYC=1, E_CYC=2, HOLD_CYC=1, POWER_US=20, FS1_US=8, FS2_US=4, SHORT_US=3, LONG_US=6.
- Reset release, then idle host → seven E pulses, each 2 cycles wide, with data 38,38,38,38,0C,01,06 and rs=0. init_done rises exactly at cycle 78. dbg_step steps 0→1…7→8.
- After init, send data 0x41 (rs=1) → lcd_e high 2 cycles starting 2 cycles after accept. in_ready returns 8 cycles after accept; lcd_data is still 0x41.
- Send command 0x01 → in_ready returns 11 cycles after accept (long wait). Command 0x04 → returns after 8 cycles (short wait).
- Hold in_valid high with 4 bytes queued → exactly one accept per transfer. No byte is lost or duplicated, and the pulses appear in order.
- Pulse reinit together with in_valid in IDLE → no byte accepted and init_done=0. The full init repeats, taking 78 cycles.
- Assert reset during a PULSE → lcd_e=0 and in_ready=0 on the next edge, and all outputs take their reset values.
